// File: rtl/curve_lut_stream.sv
// Streaming tone-curve lookup: clamp, index a writable curve table, optional lerp.
// Define CURVE_LUT_STREAM_LERP_EN to build in the second read port and interpolation.
module curve_lut_stream #(
  parameter int WIDTH     = 16,
  parameter int ADDR_W    = 8,
  parameter int SHIFT     = 2,
  parameter int CLAMP_MAX = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  input  logic              cfg_wen,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [WIDTH-1:0]  cfg_wdata,
  output logic              cfg_busy
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic signed [WIDTH-1:0] CMAX = WIDTH'(CLAMP_MAX);

  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] ctr;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [2:1]        vld_pipe;
  logic              adv, accept;
  logic signed [WIDTH-1:0] sin, c;
  logic [ADDR_W-1:0] s1_idx;
  logic [WIDTH-1:0]  lo, result;

  always_comb begin
    state_nxt = state;
    if (state == CLEAR && &ctr) state_nxt = RUN;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLEAR;
      ctr   <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) ctr <= ctr + 1'b1;
    end
  end

  // Table has no reset: CLEAR rebuilds the identity curve one entry per cycle.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == CLEAR)
        mem[ctr] <= WIDTH'(ctr) << SHIFT;
      else if (cfg_wen)
        mem[cfg_addr] <= cfg_wdata;
    end
  end

  assign out_valid = vld_pipe[2];
  assign cfg_busy  = (state == CLEAR);
  assign adv       = !out_valid || out_ready;
  assign in_ready  = (state == RUN) && adv && !cfg_wen;
  assign accept    = in_valid && in_ready;

  assign sin = $signed(in_data);
  always_comb begin
    c = sin;
    if (sin < 0)         c = '0;
    else if (sin > CMAX) c = CMAX;
  end

`ifdef CURVE_LUT_STREAM_LERP_EN
  localparam int PW = WIDTH + SHIFT + 1;
  logic [SHIFT-1:0]  s1_frac;
  logic [ADDR_W-1:0] hi_idx;
  logic [WIDTH-1:0]  hi;
  logic signed [PW-1:0] lo_x, hi_x, diff, prod, sum;

  always_ff @(posedge clk) begin
    if (!rst_n)      s1_frac <= '0;
    else if (accept) s1_frac <= c[SHIFT-1:0];
  end

  // Top entry reuses itself as the upper neighbour rather than wrapping to 0.
  assign hi_idx = (&s1_idx) ? s1_idx : s1_idx + 1'b1;
  assign lo     = mem[s1_idx];
  assign hi     = mem[hi_idx];

  always_comb begin
    lo_x = {{(SHIFT+1){lo[WIDTH-1]}}, lo};
    hi_x = {{(SHIFT+1){hi[WIDTH-1]}}, hi};
    diff = hi_x - lo_x;
    prod = diff * $signed({{(WIDTH+1){1'b0}}, s1_frac});
    sum  = lo_x + (prod >>> SHIFT);
    if (sum[PW-1:WIDTH-1] == {(SHIFT+2){sum[PW-1]}})
      result = sum[WIDTH-1:0];
    else
      result = sum[PW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  assign lo     = mem[s1_idx];
  assign result = lo;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_idx   <= '0;
      out_data <= '0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[1], accept};
      if (accept) s1_idx <= ADDR_W'(c >> SHIFT);
      out_data <= result;
    end
  end
endmodule

// File: tb/tb_curve_lut_stream.sv
// Scoreboard bench for curve_lut_stream: driver pushes model results, negedge monitor pops.
module tb_curve_lut_stream;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        cfg_wen = 1'b0;
  logic [7:0]  cfg_addr = '0;
  logic [15:0] cfg_wdata = '0;
  logic        cfg_busy;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  int tbl [256];
  bit rand_bp = 1'b0;
  bit prev_stall = 1'b0;
  logic [15:0] prev_data;

  always #5 clk = ~clk;

  curve_lut_stream dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_wen(cfg_wen), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_busy(cfg_busy)
  );

  // Reference curve: clamp, index, optional floor-lerp, saturate.
  function automatic logic [15:0] model(input logic [15:0] d);
    int x, c, idx, fr, lo, hi, r;
    x = int'($signed(d));
    c = (x < 0) ? 0 : ((x > 1023) ? 1023 : x);
    idx = c / 4;
    fr  = c % 4;
    lo  = tbl[idx];
    hi  = tbl[(idx == 255) ? 255 : idx + 1];
`ifdef CURVE_LUT_STREAM_LERP_EN
    r = lo + (((hi - lo) * fr) >>> 2);
`else
    r = lo + 0 * hi * fr;
`endif
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  task automatic identity();
    for (int i = 0; i < 256; i++) tbl[i] = i * 4;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    out_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst_n) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        checks++;
        if (!out_valid || out_data !== prev_data) begin
          failures++;
          $display("FAIL stall_hold actual=%0d/%0d required=1/%0d", out_valid, out_data, prev_data);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output actual=%0d required=none", out_data);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            failures++;
            $display("FAIL out_data actual=%0d required=%0d", $signed(out_data), $signed(e));
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // Starts one cycle after rst_n rises; in_ready must come up after exactly 256 edges.
  task automatic wait_clear();
    int cnt;
    bit ov;
    cnt = 0;
    ov = 1'b0;
    while (!in_ready && cnt < 1000) begin
      @(posedge clk); #1;
      cnt++;
      if (out_valid) ov = 1'b1;
    end
    chk("clear_cycles", cnt, 256);
    chk("clear_out_valid", {31'd0, ov}, 0);
    chk("clear_busy_low", {31'd0, cfg_busy}, 0);
  endtask

  task automatic send(input logic [15:0] d, input logic [15:0] e);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=0 required=1");
    end else exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [15:0] v);
    cfg_wen = 1'b1; cfg_addr = a; cfg_wdata = v;
    @(negedge clk);
    tbl[a] = int'($signed(v));
    @(posedge clk); #1;
    cfg_wen = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 1000 && exp_q.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic [15:0] d;
    identity();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_data", {16'd0, out_data}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_cfg_busy", {31'd0, cfg_busy}, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_clear();

`ifdef CURVE_LUT_STREAM_LERP_EN
    send(-16'sd5, 16'd0); send(16'd0, 16'd0); send(16'd513, 16'd513);
`else
    send(-16'sd5, 16'd0); send(16'd0, 16'd0); send(16'd513, 16'd512);
`endif
    send(16'd1023, 16'd1020); send(16'd4000, 16'd1020);
    drain();

    cfg_write(8'd128, 16'd1000);
    cfg_write(8'd129, 16'd516);
`ifdef CURVE_LUT_STREAM_LERP_EN
    send(16'd514, 16'd758);
`else
    send(16'd514, 16'd1000);
`endif
    drain();

    // Write collides with an input: write wins this cycle, sample goes next cycle.
    cfg_wen = 1'b1; cfg_addr = 8'd10; cfg_wdata = 16'd777;
    in_valid = 1'b1; in_data = 16'd41;
    @(negedge clk);
    chk("cfg_blocks_in_ready", {31'd0, in_ready}, 0);
    tbl[10] = 777;
    @(posedge clk); #1;
    cfg_wen = 1'b0;
    @(negedge clk);
    chk("in_ready_after_cfg", {31'd0, in_ready}, 1);
    exp_q.push_back(model(16'd41));
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    for (int i = 0; i < 8; i++) cfg_write(8'($urandom_range(0, 255)), 16'($urandom));
    rand_bp = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      if ($urandom_range(0, 4) == 0) d = 16'($urandom);
      else d = 16'($urandom_range(0, 1300)) - 16'd150;
      send(d, model(d));
    end
    rand_bp = 1'b0;
    drain();

    // Reset with two samples in flight; they are discarded.
    in_valid = 1'b1; in_data = 16'd100;
    @(posedge clk); #1;
    in_data = 16'd200;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, out_valid}, 0);
    chk("midrst_cfg_busy", {31'd0, cfg_busy}, 1);
    exp_q.delete();
    identity();
    wait_clear();
`ifdef CURVE_LUT_STREAM_LERP_EN
    send(16'd514, 16'd514);
`else
    send(16'd514, 16'd512);
`endif
    send(16'd43, 16'd43 & 16'hFFFF & ((`ifdef CURVE_LUT_STREAM_LERP_EN 16'hFFFF `else 16'hFFFC `endif)));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
